// File: rtl/fpga_cfg_pkg.sv
// Shared constants for the configuration-chain loader: register map, bit
// positions in CTRL/STATUS, and the shift sequencer state encoding.
package fpga_cfg_pkg;

   localparam logic [2:0] ADR_CTRL   = 3'd0;
   localparam logic [2:0] ADR_LEN    = 3'd1;
   localparam logic [2:0] ADR_DATA   = 3'd2;
   localparam logic [2:0] ADR_STATUS = 3'd3;
   localparam logic [2:0] ADR_TAIL   = 3'd4;

   localparam int CTRL_START   = 0;
   localparam int CTRL_PRST    = 1;
   localparam int CTRL_ABORT   = 2;
   localparam int CTRL_DIV_LSB = 8;

   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_FULL    = 3;
   localparam int ST_OVF     = 4;
   localparam int ST_ABT     = 5;
   localparam int ST_LVL_LSB = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_LOW  = 3'd2,
      S_HIGH = 3'd3,
      S_DONE = 3'd4
   } cfg_state_e;

endpackage

// File: rtl/cfg_sync_fifo.sv
// Single-clock FIFO with fall-through read data, occupancy level and a
// synchronous flush. A push into a full FIFO is accepted only alongside a pop.
module cfg_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge i_clk) begin
      if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push_ok && !w_pop_ok)      r_level <= r_level + (AW+1)'(1);
         else if (!w_push_ok && w_pop_ok) r_level <= r_level - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone-slave sequencer that streams FIFO'd 32-bit words LSB-first onto the
// fabric configuration chain with a programmable prog_clk, capturing ccff_tail.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 20,
   parameter int DIV_W      = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [2:0]  wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        prog_clk_o,
   output logic        ccff_head_o,
   output logic        prog_reset_o,
   input  logic        ccff_tail_i,
   output logic        cfg_busy_o,
   output logic [2:0]  dbg_state_o
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              r_ack;
   logic [31:0]       r_dat;
   logic              r_prog_reset;
   logic [DIV_W-1:0]  r_div;
   logic [LEN_W-1:0]  r_len;
   cfg_state_e        r_state;
   logic [DIV_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_remain;
   logic [4:0]        r_idx;
   logic [31:0]       r_shreg;
   logic [31:0]       r_tail;
   logic              r_prog_clk;
   logic              r_head;
   logic              r_done;
   logic              r_ovf;
   logic              r_abt;

   logic              w_req, w_wr, w_rd, w_start, w_abort, w_push, w_pop;
   logic              w_full, w_empty, w_busy, w_tail_shift, w_unused;
   logic [31:0]       w_fifo_dout, w_rdata, w_shreg_nxt;
   logic [LVL_W-1:0]  w_level;
   logic [LEN_W-1:0]  w_remain_nxt;
   logic [DIV_W-1:0]  w_cnt_nxt;
   logic [4:0]        w_idx_nxt;
   cfg_state_e        w_state_nxt;

   // Bus handshake: a request is stb&cyc while no ack is outstanding; it is
   // acted on in that cycle and acked exactly one cycle later for one cycle.
   assign w_req    = wbs_stb_i && wbs_cyc_i && !r_ack;
   assign w_wr     = w_req && wbs_we_i;
   assign w_rd     = w_req && !wbs_we_i;
   assign w_start  = w_wr && (wbs_adr_i == ADR_CTRL) && wbs_dat_i[CTRL_START];
   assign w_abort  = w_wr && (wbs_adr_i == ADR_CTRL) && wbs_dat_i[CTRL_ABORT];
   assign w_push   = w_wr && (wbs_adr_i == ADR_DATA);
   assign w_busy   = (r_state == S_LOAD) || (r_state == S_LOW) || (r_state == S_HIGH);
   assign w_unused = ^wbs_sel_i;

   cfg_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_flush (w_abort),
      .i_push  (w_push),
      .i_din   (wbs_dat_i),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_comb begin
      w_rdata = '0;
      case (wbs_adr_i)
         ADR_CTRL: begin
            w_rdata[CTRL_PRST]              = r_prog_reset;
            w_rdata[CTRL_DIV_LSB +: DIV_W]  = r_div;
         end
         ADR_LEN:  w_rdata[LEN_W-1:0] = r_len;
         ADR_STATUS: begin
            w_rdata[ST_BUSY]             = w_busy;
            w_rdata[ST_DONE]             = r_done;
            w_rdata[ST_EMPTY]            = w_empty;
            w_rdata[ST_FULL]             = w_full;
            w_rdata[ST_OVF]              = r_ovf;
            w_rdata[ST_ABT]              = r_abt;
            w_rdata[ST_LVL_LSB +: 8]     = 8'(w_level);
         end
         ADR_TAIL: w_rdata = r_tail;
         default:  w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack        <= 1'b0;
         r_dat        <= '0;
         r_prog_reset <= 1'b1;
         r_div        <= '0;
         r_len        <= '0;
         r_done       <= 1'b0;
         r_ovf        <= 1'b0;
         r_abt        <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rd ? w_rdata : '0;
         if (w_wr && wbs_adr_i == ADR_CTRL) begin
            r_prog_reset <= wbs_dat_i[CTRL_PRST];
            r_div        <= wbs_dat_i[CTRL_DIV_LSB +: DIV_W];
         end
         if (w_wr && wbs_adr_i == ADR_LEN) r_len <= wbs_dat_i[LEN_W-1:0];
         // Sticky flags: a new event in the same cycle as a W1C wins.
         if (w_state_nxt == S_DONE) r_done <= 1'b1;
         else if (w_wr && wbs_adr_i == ADR_STATUS && wbs_dat_i[ST_DONE]) r_done <= 1'b0;
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         else if (w_wr && wbs_adr_i == ADR_STATUS && wbs_dat_i[ST_OVF]) r_ovf <= 1'b0;
         if (w_abort) r_abt <= 1'b1;
         else if (w_wr && wbs_adr_i == ADR_STATUS && wbs_dat_i[ST_ABT]) r_abt <= 1'b0;
      end
   end

   // The word fetch in LOAD lengthens the low phase at a word boundary by one cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_remain_nxt = r_remain;
      w_idx_nxt    = r_idx;
      w_shreg_nxt  = r_shreg;
      w_pop        = 1'b0;
      w_tail_shift = 1'b0;
      if (w_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               if (r_len == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt  = S_LOAD;
                  w_remain_nxt = r_len;
               end
            end
            S_LOAD: if (!w_empty) begin
               w_pop       = 1'b1;
               w_shreg_nxt = w_fifo_dout;
               w_idx_nxt   = '0;
               w_cnt_nxt   = r_div;
               w_state_nxt = S_LOW;
            end
            S_LOW: if (r_cnt == '0) begin
               w_state_nxt  = S_HIGH;
               w_cnt_nxt    = r_div;
               w_tail_shift = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - DIV_W'(1);
            end
            S_HIGH: if (r_cnt == '0) begin
               w_remain_nxt = r_remain - LEN_W'(1);
               if (r_remain == LEN_W'(1)) begin
                  w_state_nxt = S_DONE;
               end else if (r_idx == 5'd31) begin
                  w_state_nxt = S_LOAD;
               end else begin
                  w_idx_nxt   = r_idx + 5'd1;
                  w_cnt_nxt   = r_div;
                  w_state_nxt = S_LOW;
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_W'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_remain   <= '0;
         r_idx      <= '0;
         r_shreg    <= '0;
         r_tail     <= '0;
         r_prog_clk <= 1'b0;
         r_head     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_remain   <= w_remain_nxt;
         r_idx      <= w_idx_nxt;
         r_shreg    <= w_shreg_nxt;
         if (w_tail_shift) r_tail <= {r_tail[30:0], ccff_tail_i};
         r_prog_clk <= (w_state_nxt == S_HIGH);
         r_head     <= ((w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH)) ?
                       w_shreg_nxt[w_idx_nxt] : 1'b0;
      end
   end

   assign wbs_ack_o    = r_ack;
   assign wbs_dat_o    = r_dat;
   assign prog_clk_o   = r_prog_clk;
   assign ccff_head_o  = r_head;
   assign prog_reset_o = r_prog_reset;
   assign cfg_busy_o   = w_busy;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: bus register access, serial bitstream
// order, prog_clk timing, FIFO stall/overflow, abort and asynchronous reset.
module tb_fpga_cfg_loader;

   localparam logic [2:0] A_CTRL = 3'd0, A_LEN = 3'd1, A_DATA = 3'd2,
                          A_STATUS = 3'd3, A_TAIL = 3'd4, A_RSVD = 3'd5;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_DONE = 3'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hf;
   logic [2:0]  adr = '0;
   logic [31:0] dat_i = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic        prog_clk, head, prog_reset, tail, busy;
   logic [2:0]  dbg;

   int checks = 0;
   int failures = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   // Chain loopback: the tail returns what the head drives.
   assign tail = head;

   fpga_cfg_loader dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_adr_i    (adr),
      .wbs_dat_i    (dat_i),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (dat_o),
      .prog_clk_o   (prog_clk),
      .ccff_head_o  (head),
      .prog_reset_o (prog_reset),
      .ccff_tail_i  (tail),
      .cfg_busy_o   (busy),
      .dbg_state_o  (dbg)
   );

   // prog_clk monitor: rising edges, head bit at each rise, period extremes.
   int          edges = 0, load_visits = 0, per_min = 0, per_max = 0;
   int          last_rise = 0, cyc_n = 0, clr_gen = 0, seen_gen = 0;
   logic [63:0] cap = '0;
   logic        pclk_q = 1'b0;
   logic [2:0]  st_q = '0;

   always @(negedge clk) begin
      cyc_n++;
      if (clr_gen != seen_gen) begin
         seen_gen = clr_gen;
         edges = 0; load_visits = 0; per_min = 1000; per_max = 0; cap = '0;
      end
      if (prog_clk && !pclk_q) begin
         if (edges < 64) cap[edges] = head;
         if (edges > 0) begin
            if (cyc_n - last_rise < per_min) per_min = cyc_n - last_rise;
            if (cyc_n - last_rise > per_max) per_max = cyc_n - last_rise;
         end
         last_rise = cyc_n;
         edges++;
      end
      if (dbg == ST_LOAD && st_q != ST_LOAD) load_visits++;
      pclk_q = prog_clk;
      st_q = dbg;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] q);
      int n = 0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
      do begin
         @(posedge clk); #1; n++;
      end while (ack !== 1'b1 && n < 8);
      q = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      if (ack !== 1'b1) check("wb_ack_timeout", 32'(ack), 32'd1);
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_access(1'b1, a, d, q);
   endtask

   task automatic wb_read(input logic [2:0] a, output logic [31:0] q);
      wb_access(1'b0, a, 32'h0, q);
   endtask

   task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
      int n = 0;
      while (dbg !== s && n < max_cyc) begin
         @(posedge clk); #1; n++;
      end
      if (dbg !== s) check(tag, 32'(dbg), 32'(s));
   endtask

   task automatic wait_edges(input int k, input int max_cyc, input string tag);
      int n = 0;
      while (edges < k && n < max_cyc) begin
         @(posedge clk); #2; n++;
      end
      if (edges < k) check(tag, 32'(edges), 32'(k));
   endtask

   task automatic mon_clear();
      clr_gen++;
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_prog_reset", 32'(prog_reset), 32'd1);
      check("rst_prog_clk", 32'(prog_clk), 32'd0);
      check("rst_head", 32'(head), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat_o", dat_o, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      wb_read(A_STATUS, rd); check("rst_status", rd, 32'h0000_0004);
      wb_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0000_0002);
      wb_read(A_TAIL, rd);   check("rst_tail", rd, 32'h0);
      wb_read(A_LEN, rd);    check("rst_len", rd, 32'h0);

      // 8-bit job, div=0
      wb_write(A_CTRL, 32'h0);
      check("prog_reset_cleared", 32'(prog_reset), 32'd0);
      wb_write(A_LEN, 32'd8);
      wb_write(A_DATA, 32'h0000_00A5);
      mon_clear();
      wb_write(A_CTRL, 32'h1);
      wait_state(ST_IDLE, 200, "j8_idle_timeout");
      check("j8_edges", 32'(edges), 32'd8);
      check("j8_bits", 32'(cap[7:0]), 32'h0000_00A5);
      check("j8_per_min", 32'(per_min), 32'd2);
      check("j8_per_max", 32'(per_max), 32'd2);
      wb_read(A_STATUS, rd); check("j8_status", rd, 32'h0000_0006);
      wb_read(A_TAIL, rd);   check("j8_tail", rd, 32'h0000_00A5);
      wb_write(A_STATUS, 32'h2);
      wb_read(A_STATUS, rd); check("done_w1c", rd, 32'h0000_0004);

      // 40-bit job over two words, div=3
      wb_write(A_CTRL, 32'h0000_0300);
      wb_read(A_CTRL, rd); check("ctrl_div_rb", rd, 32'h0000_0300);
      wb_write(A_LEN, 32'd40);
      wb_write(A_DATA, 32'h1234_5678);
      wb_write(A_DATA, 32'hABCD_EFC3);
      mon_clear();
      wb_write(A_CTRL, 32'h0000_0301);
      wait_state(ST_IDLE, 2000, "j40_idle_timeout");
      check("j40_edges", 32'(edges), 32'd40);
      check("j40_word0", cap[31:0], 32'h1234_5678);
      check("j40_word1_low", 32'(cap[39:32]), 32'h0000_00C3);
      check("j40_per_min", 32'(per_min), 32'd8);
      check("j40_load_visits", 32'(load_visits), 32'd2);
      wb_read(A_STATUS, rd); check("j40_status", rd, 32'h0000_0006);
      wb_write(A_STATUS, 32'h2);

      // 64-bit job with one word queued: stall, then resume
      wb_write(A_CTRL, 32'h0);
      wb_write(A_LEN, 32'd64);
      wb_write(A_DATA, 32'hDEAD_BEEF);
      mon_clear();
      wb_write(A_CTRL, 32'h1);
      wait_edges(32, 500, "j64_first_word_timeout");
      repeat (20) @(posedge clk);
      #1;
      check("stall_edges", 32'(edges), 32'd32);
      check("stall_prog_clk", 32'(prog_clk), 32'd0);
      check("stall_state", 32'(dbg), 32'(ST_LOAD));
      wb_read(A_STATUS, rd); check("stall_status", rd, 32'h0000_0005);
      wb_write(A_DATA, 32'h0F0F_0F0F);
      wait_state(ST_IDLE, 500, "j64_idle_timeout");
      check("j64_edges", 32'(edges), 32'd64);
      check("j64_word0", cap[31:0], 32'hDEAD_BEEF);
      check("j64_word1", cap[63:32], 32'h0F0F_0F0F);
      wb_read(A_TAIL, rd); check("j64_tail", rd, 32'hF0F0_F0F0);
      wb_write(A_STATUS, 32'h2);

      // FIFO fill and overflow
      wb_write(A_DATA, 32'h11);
      wb_write(A_DATA, 32'h22);
      wb_write(A_DATA, 32'h33);
      wb_write(A_DATA, 32'h44);
      wb_read(A_STATUS, rd); check("fifo_full_status", rd, 32'h0000_0408);
      wb_write(A_DATA, 32'h55);
      wb_read(A_STATUS, rd); check("overflow_status", rd, 32'h0000_0418);
      wb_write(A_STATUS, 32'h10);
      wb_read(A_STATUS, rd); check("overflow_w1c", rd, 32'h0000_0408);
      wb_read(A_DATA, rd);   check("data_read_zero", rd, 32'h0);
      wb_read(A_RSVD, rd);   check("rsvd_read_zero", rd, 32'h0);
      wb_write(A_CTRL, 32'h4);
      wb_read(A_STATUS, rd); check("idle_abort_flush", rd, 32'h0000_0024);
      wb_write(A_STATUS, 32'h20);
      wb_read(A_STATUS, rd); check("aborted_w1c", rd, 32'h0000_0004);

      // Abort mid-job, then an empty job
      wb_write(A_CTRL, 32'h0000_0300);
      wb_write(A_LEN, 32'd32);
      wb_write(A_DATA, 32'hFFFF_FFFF);
      mon_clear();
      wb_write(A_CTRL, 32'h0000_0301);
      wait_edges(10, 500, "abort_edges_timeout");
      check("pre_abort_prog_clk", 32'(prog_clk), 32'd1);
      wb_write(A_CTRL, 32'h0000_0304);
      check("abort_prog_clk", 32'(prog_clk), 32'd0);
      check("abort_head", 32'(head), 32'd0);
      check("abort_state", 32'(dbg), 32'(ST_IDLE));
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_more_edges", 32'(edges), 32'd10);
      wb_read(A_STATUS, rd); check("abort_status", rd, 32'h0000_0024);
      wb_write(A_STATUS, 32'h20);
      wb_write(A_LEN, 32'd0);
      wb_write(A_CTRL, 32'h1);
      check("len0_state_done", 32'(dbg), 32'(ST_DONE));
      @(posedge clk); #1;
      check("len0_state_idle", 32'(dbg), 32'(ST_IDLE));
      wb_read(A_STATUS, rd); check("len0_status", rd, 32'h0000_0006);
      check("len0_no_edges", 32'(edges), 32'd10);
      wb_write(A_STATUS, 32'h2);

      // Asynchronous reset in the middle of a shift
      wb_write(A_CTRL, 32'h0000_0100);
      wb_write(A_LEN, 32'd32);
      wb_write(A_DATA, 32'hFFFF_FFFF);
      mon_clear();
      wb_write(A_CTRL, 32'h0000_0101);
      wait_edges(5, 500, "arst_edges_timeout");
      check("pre_arst_head", 32'(head), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_prog_clk", 32'(prog_clk), 32'd0);
      check("arst_head", 32'(head), 32'd0);
      check("arst_prog_reset", 32'(prog_reset), 32'd1);
      check("arst_state", 32'(dbg), 32'(ST_IDLE));
      @(negedge clk) rst_n = 1'b1;
      wb_read(A_STATUS, rd); check("arst_status", rd, 32'h0000_0004);
      wb_read(A_CTRL, rd);   check("arst_ctrl", rd, 32'h0000_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
